// File: rtl/arc_pkg.sv
// Shared types for the unified memory-port arbiter; no logic, no latency.
// Backpressure: n/a (types and constants only).
package arc_pkg;
    localparam int ARB_WORD_BYTES = 4;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_BUSY_IF,
        ARB_BUSY_DM,
        ARB_DONE_IF,
        ARB_DONE_DM
    } arb_state_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side and memory-side handshake bundle of the arbiter; pure wiring, no latency.
// Backpressure: requests are held until their valid pulse; memory throttles with i_mem_ready.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_if_req;
    logic [AW-1:0] i_if_addr;
    logic [DW-1:0] o_if_rdata;
    logic          o_if_valid;
    logic          i_dm_req;
    logic          i_dm_we;
    logic [AW-1:0] i_dm_addr;
    logic [DW-1:0] i_dm_wdata;
    logic [DW-1:0] o_dm_rdata;
    logic          o_dm_valid;
    logic          o_stall;
    logic          o_mem_req;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic [DW-1:0] i_mem_rdata;
    logic          i_mem_ready;
    logic          o_err;

    modport slave (
        input  i_if_req, i_if_addr, i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata,
        input  i_mem_rdata, i_mem_ready,
        output o_if_rdata, o_if_valid, o_dm_rdata, o_dm_valid, o_stall,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_err
    );

    modport master (
        output i_if_req, i_if_addr, i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata,
        output i_mem_rdata, i_mem_ready,
        input  o_if_rdata, o_if_valid, o_dm_rdata, o_dm_valid, o_stall,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_err
    );
endinterface

// File: rtl/mem_arb_watchdog.sv
// Counts BUSY cycles without ready; expire is combinational on the TIMEOUT_CYCLES-th such cycle.
// Backpressure: none; it only observes the arbiter's busy/ready handshake.
module mem_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start,
    input  logic i_busy,
    input  logic i_ready,
    output logic o_expire
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign o_expire = i_busy & ~i_ready & (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (i_start) begin
            cnt_d = '0;
        end else if (i_busy && !i_ready && !o_expire) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter onto one memory port, data first; >=3 cycles per access, valid at N+2 (ARB_TIMEOUT_EN adds a watchdog).
// Backpressure: o_stall holds the pipeline while any request is pending; BUSY waits on i_mem_ready.
module mem_port_arbiter
    import arc_pkg::*;
#(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    mem_port_arbiter_if.slave bus
);
    arb_state_t    state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          err_q, err_d;
    logic          expire;

`ifdef ARB_TIMEOUT_EN
    logic wd_start;
    logic wd_busy;

    assign wd_start = (state_q == ARB_IDLE) & (bus.i_dm_req | bus.i_if_req);
    assign wd_busy  = (state_q == ARB_BUSY_IF) | (state_q == ARB_BUSY_DM);

    mem_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (wd_start),
        .i_busy  (wd_busy),
        .i_ready (bus.i_mem_ready),
        .o_expire(expire)
    );
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign expire         = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        err_d       = err_q | expire;

        case (state_q)
            ARB_IDLE: begin
                // Data belongs to the older instruction, so it wins a tie.
                if (bus.i_dm_req) begin
                    state_d     = ARB_BUSY_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.i_dm_we;
                    mem_addr_d  = bus.i_dm_addr;
                    mem_wdata_d = bus.i_dm_wdata;
                end else if (bus.i_if_req) begin
                    state_d     = ARB_BUSY_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.i_if_addr;
                    mem_wdata_d = '0;
                end
            end
            ARB_BUSY_IF: begin
                if (bus.i_mem_ready) begin
                    state_d    = ARB_DONE_IF;
                    mem_req_d  = 1'b0;
                    if_rdata_d = bus.i_mem_rdata;
                end else if (expire) begin
                    state_d    = ARB_DONE_IF;
                    mem_req_d  = 1'b0;
                    if_rdata_d = '0;
                end
            end
            ARB_BUSY_DM: begin
                if (bus.i_mem_ready) begin
                    state_d   = ARB_DONE_DM;
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        dm_rdata_d = bus.i_mem_rdata;
                    end
                end else if (expire) begin
                    state_d    = ARB_DONE_DM;
                    mem_req_d  = 1'b0;
                    dm_rdata_d = '0;
                end
            end
            ARB_DONE_IF, ARB_DONE_DM: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ARB_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            err_q       <= err_d;
        end
    end

    assign bus.o_mem_req   = mem_req_q;
    assign bus.o_mem_we    = mem_we_q;
    assign bus.o_mem_addr  = mem_addr_q;
    assign bus.o_mem_wdata = mem_wdata_q;
    assign bus.o_if_rdata  = if_rdata_q;
    assign bus.o_dm_rdata  = dm_rdata_q;
    assign bus.o_if_valid  = (state_q == ARB_DONE_IF);
    assign bus.o_dm_valid  = (state_q == ARB_DONE_DM);
    assign bus.o_err       = err_q;
    assign bus.o_stall     = (bus.i_if_req & ~bus.o_if_valid) | (bus.i_dm_req & ~bus.o_dm_valid);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, tie, delayed store, async reset, back-to-back, timeout.
// Inputs change and outputs are sampled 1 ns after the rising edge.
module tb_mem_port_arbiter;
    import arc_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(
        .AW            (32),
        .DW            (32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_req"}, {31'd0, bus.o_mem_req}, 32'd0);
        chk({tag, "_mem_we"}, {31'd0, bus.o_mem_we}, 32'd0);
        chk({tag, "_mem_addr"}, bus.o_mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, bus.o_mem_wdata, 32'd0);
        chk({tag, "_if_valid"}, {31'd0, bus.o_if_valid}, 32'd0);
        chk({tag, "_dm_valid"}, {31'd0, bus.o_dm_valid}, 32'd0);
        chk({tag, "_if_rdata"}, bus.o_if_rdata, 32'd0);
        chk({tag, "_dm_rdata"}, bus.o_dm_rdata, 32'd0);
        chk({tag, "_err"}, {31'd0, bus.o_err}, 32'd0);
    endtask

    initial begin
        logic [31:0] fetch_data [3];
        checks   = 0;
        failures = 0;
        fetch_data[0] = 32'h2408_0001;
        fetch_data[1] = 32'h2409_0002;
        fetch_data[2] = 32'h010A_5020;

        rst_n           = 1'b0;
        bus.i_if_req    = 1'b0;
        bus.i_if_addr   = '0;
        bus.i_dm_req    = 1'b0;
        bus.i_dm_we     = 1'b0;
        bus.i_dm_addr   = '0;
        bus.i_dm_wdata  = '0;
        bus.i_mem_rdata = '0;
        bus.i_mem_ready = 1'b0;
        step();
        step();
        chk_all_zero("reset");
        chk("reset_stall", {31'd0, bus.o_stall}, 32'd0);
        rst_n = 1'b1;
        step();

        // Single fetch, ready on the first BUSY cycle.
        bus.i_if_req  = 1'b1;
        bus.i_if_addr = 32'h0000_0040;
        #1;
        chk("f1_stall_n", {31'd0, bus.o_stall}, 32'd1);
        step();
        chk("f1_mem_req", {31'd0, bus.o_mem_req}, 32'd1);
        chk("f1_mem_we", {31'd0, bus.o_mem_we}, 32'd0);
        chk("f1_mem_addr", bus.o_mem_addr, 32'h0000_0040);
        chk("f1_stall_n1", {31'd0, bus.o_stall}, 32'd1);
        chk("f1_valid_n1", {31'd0, bus.o_if_valid}, 32'd0);
        bus.i_mem_ready = 1'b1;
        bus.i_mem_rdata = 32'h8C22_0004;
        step();
        chk("f1_valid", {31'd0, bus.o_if_valid}, 32'd1);
        chk("f1_rdata", bus.o_if_rdata, 32'h8C22_0004);
        chk("f1_mem_req_drop", {31'd0, bus.o_mem_req}, 32'd0);
        chk("f1_stall_n2", {31'd0, bus.o_stall}, 32'd0);
        bus.i_if_req    = 1'b0;
        bus.i_mem_ready = 1'b0;
        step();
        chk("f1_valid_pulse", {31'd0, bus.o_if_valid}, 32'd0);

        // Fetch and load in the same cycle: load goes first.
        bus.i_if_req  = 1'b1;
        bus.i_if_addr = 32'h0000_0044;
        bus.i_dm_req  = 1'b1;
        bus.i_dm_we   = 1'b0;
        bus.i_dm_addr = 32'h0000_0100;
        step();
        chk("tie_first_addr", bus.o_mem_addr, 32'h0000_0100);
        chk("tie_first_we", {31'd0, bus.o_mem_we}, 32'd0);
        chk("tie_stall_busy", {31'd0, bus.o_stall}, 32'd1);
        bus.i_mem_ready = 1'b1;
        bus.i_mem_rdata = 32'h1111_2222;
        step();
        chk("tie_dm_valid", {31'd0, bus.o_dm_valid}, 32'd1);
        chk("tie_dm_rdata", bus.o_dm_rdata, 32'h1111_2222);
        chk("tie_if_not_yet", {31'd0, bus.o_if_valid}, 32'd0);
        chk("tie_stall_fetch_pending", {31'd0, bus.o_stall}, 32'd1);
        bus.i_dm_req    = 1'b0;
        bus.i_mem_ready = 1'b0;
        step();
        chk("tie_idle_no_req", {31'd0, bus.o_mem_req}, 32'd0);
        chk("tie_stall_idle", {31'd0, bus.o_stall}, 32'd1);
        step();
        chk("tie_second_addr", bus.o_mem_addr, 32'h0000_0044);
        chk("tie_second_req", {31'd0, bus.o_mem_req}, 32'd1);
        bus.i_mem_ready = 1'b1;
        bus.i_mem_rdata = 32'h3333_4444;
        step();
        chk("tie_if_valid", {31'd0, bus.o_if_valid}, 32'd1);
        chk("tie_if_rdata", bus.o_if_rdata, 32'h3333_4444);
        chk("tie_stall_done", {31'd0, bus.o_stall}, 32'd0);
        bus.i_if_req    = 1'b0;
        bus.i_mem_ready = 1'b0;
        step();

        // Store with ready held off for 5 BUSY cycles.
        bus.i_dm_req    = 1'b1;
        bus.i_dm_we     = 1'b1;
        bus.i_dm_addr   = 32'h0000_0200;
        bus.i_dm_wdata  = 32'hCAFE_F00D;
        bus.i_mem_rdata = 32'hDEAD_BEEF;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("st_req_hold", {31'd0, bus.o_mem_req}, 32'd1);
            chk("st_we_hold", {31'd0, bus.o_mem_we}, 32'd1);
            chk("st_addr_hold", bus.o_mem_addr, 32'h0000_0200);
            chk("st_wdata_hold", bus.o_mem_wdata, 32'hCAFE_F00D);
            chk("st_no_valid", {31'd0, bus.o_dm_valid}, 32'd0);
            step();
        end
        bus.i_mem_ready = 1'b1;
        chk("st_addr_at_ready", bus.o_mem_addr, 32'h0000_0200);
        step();
        chk("st_valid", {31'd0, bus.o_dm_valid}, 32'd1);
        chk("st_rdata_kept", bus.o_dm_rdata, 32'h1111_2222);
        bus.i_dm_req    = 1'b0;
        bus.i_dm_we     = 1'b0;
        bus.i_mem_ready = 1'b0;
        step();
        chk("st_valid_pulse", {31'd0, bus.o_dm_valid}, 32'd0);

        // Asynchronous reset in the middle of a load.
        bus.i_dm_req  = 1'b1;
        bus.i_dm_addr = 32'h0000_0300;
        step();
        chk("rst_busy_req", {31'd0, bus.o_mem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_async");
        bus.i_dm_req = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        bus.i_if_req    = 1'b1;
        bus.i_if_addr   = 32'h0000_0004;
        step();
        chk("rst_after_addr", bus.o_mem_addr, 32'h0000_0004);
        chk("rst_after_req", {31'd0, bus.o_mem_req}, 32'd1);
        bus.i_mem_ready = 1'b1;
        bus.i_mem_rdata = 32'h0000_5555;
        step();
        chk("rst_after_valid", {31'd0, bus.o_if_valid}, 32'd1);
        chk("rst_after_rdata", bus.o_if_rdata, 32'h0000_5555);
        bus.i_if_req = 1'b0;
        step();

        // Back-to-back fetches with ready tied high: one valid every 3 cycles.
        bus.i_mem_ready = 1'b1;
        bus.i_if_req    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.i_if_addr   = k * ARB_WORD_BYTES;
            bus.i_mem_rdata = fetch_data[k];
            chk("b2b_idle_valid", {31'd0, bus.o_if_valid}, 32'd0);
            step();
            chk("b2b_addr", bus.o_mem_addr, k * ARB_WORD_BYTES);
            chk("b2b_busy_valid", {31'd0, bus.o_if_valid}, 32'd0);
            step();
            chk("b2b_valid", {31'd0, bus.o_if_valid}, 32'd1);
            chk("b2b_rdata", bus.o_if_rdata, fetch_data[k]);
            if (k == 2) begin
                bus.i_if_req = 1'b0;
            end
            step();
        end
        chk("b2b_no_extra_req", {31'd0, bus.o_mem_req}, 32'd0);
        bus.i_mem_ready = 1'b0;
        step();
        chk("b2b_no_extra_valid", {31'd0, bus.o_if_valid}, 32'd0);

        // Memory never answers.
        bus.i_if_req  = 1'b1;
        bus.i_if_addr = 32'h0000_0080;
        step();
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            chk("to_busy_req", {31'd0, bus.o_mem_req}, 32'd1);
            chk("to_err_early", {31'd0, bus.o_err}, 32'd0);
            step();
        end
        chk("to_valid", {31'd0, bus.o_if_valid}, 32'd1);
        chk("to_rdata_zero", bus.o_if_rdata, 32'd0);
        chk("to_err_set", {31'd0, bus.o_err}, 32'd1);
        chk("to_req_drop", {31'd0, bus.o_mem_req}, 32'd0);
        bus.i_if_req = 1'b0;
        step();
        step();
        chk("to_err_sticky", {31'd0, bus.o_err}, 32'd1);
`else
        for (int i = 0; i < 20; i++) begin
            chk("nto_req_hold", {31'd0, bus.o_mem_req}, 32'd1);
            chk("nto_stall", {31'd0, bus.o_stall}, 32'd1);
            chk("nto_err", {31'd0, bus.o_err}, 32'd0);
            chk("nto_no_valid", {31'd0, bus.o_if_valid}, 32'd0);
            step();
        end
        bus.i_if_req = 1'b0;
`endif
        rst_n = 1'b0;
        #1;
        chk_all_zero("final_rst");
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
